// File: rtl/mcu_sequencer.sv
// mcu_sequencer: holds a small program of mcu instructions and issues them to
// the mcu one per clock. Captures read results, stops on an mcu opcode error,
// and treats opcode 15 as a sequencer-only HALT that never reaches the mcu.
module mcu_sequencer #(
    parameter int op_sz      = 6,
    parameter int mem_sz     = 5,
    parameter int prog_depth = 16,
    parameter int pc_w       = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            prog_we,
    input  logic [pc_w-1:0]                 prog_addr,
    input  logic [4+2*mem_sz+op_sz-1:0]     prog_data,
    input  logic [pc_w:0]                   prog_len,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [pc_w-1:0]                 err_pc,
    output logic                            rd_valid,
    output logic [op_sz-1:0]                rd_data,
    output logic [mem_sz-1:0]               mcu_op0,
    output logic [op_sz-1:0]                mcu_op1,
    output logic [mem_sz-1:0]               mcu_op2,
    output logic [3:0]                      mcu_op,
    input  logic [op_sz-1:0]                mcu_out,
    input  logic                            mcu_op_err
);

    localparam int              IW       = 4 + 2*mem_sz + op_sz;
    localparam logic [3:0]      OP_HALT  = 4'd15;
    localparam logic [3:0]      OP_READ  = 4'd7;
    localparam logic [pc_w:0]   LEN_ONE  = 1;
    localparam logic [pc_w-1:0] IDX_ONE  = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    logic [IW-1:0]     prog_mem [prog_depth];

    state_t            state_q, state_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [pc_w-1:0]   idx_q, idx_d;
    logic [pc_w:0]     len_q, len_d;
    logic              err_q, err_d;
    logic [pc_w-1:0]   err_pc_q, err_pc_d;
    logic              done_q, done_d;
    logic              rd_pend_q, rd_pend_d;
    logic [op_sz-1:0]  rd_data_q, rd_data_d;

    logic [3:0]        ir_op;
    logic [mem_sz-1:0] ir_op0;
    logic [op_sz-1:0]  ir_op1;
    logic [mem_sz-1:0] ir_op2;
    logic              issue;
    logic              last_instr;

    // Instruction word layout is {op, op2, op1, op0}, op0 in the low bits.
    assign ir_op  = ir_q[IW-1 -: 4];
    assign ir_op2 = ir_q[2*mem_sz+op_sz-1 -: mem_sz];
    assign ir_op1 = ir_q[mem_sz+op_sz-1 -: op_sz];
    assign ir_op0 = ir_q[mem_sz-1:0];

    // An instruction reaches the mcu only while running and only if it is not HALT.
    assign issue      = (state_q == S_RUN) && (ir_op != OP_HALT);
    assign last_instr = ({1'b0, idx_q} == (len_q - LEN_ONE));

    // Program memory keeps its contents across reset; loadable only while idle.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE)) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    // Instruction register is pure datapath; the mux below masks it when not running.
    always_ff @(posedge clk) begin
        ir_q <= ir_d;
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            err_pc_q  <= '0;
            done_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            err_q     <= err_d;
            err_pc_q  <= err_pc_d;
            done_q    <= done_d;
            rd_pend_q <= rd_pend_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Next-state logic: fetch/advance, error stop, HALT and drain handling.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        idx_d    = idx_q;
        len_d    = len_q;
        err_d    = err_q;
        err_pc_d = err_pc_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (prog_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        ir_d    = prog_mem[0];
                        idx_d   = '0;
                        len_d   = prog_len;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (ir_op == OP_HALT) begin
                    state_d = S_DRAIN;
                end else if (mcu_op_err) begin
                    err_d    = 1'b1;
                    err_pc_d = idx_q;
                    state_d  = S_IDLE;
                end else if (last_instr) begin
                    state_d = S_DRAIN;
                end else begin
                    ir_d  = prog_mem[idx_q + IDX_ONE];
                    idx_d = idx_q + IDX_ONE;
                end
            end
            S_DRAIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read capture: the mcu registers out when it commits a read, so the value
    // is on mcu_out in the cycle after issue; present it then and hold it after.
    always_comb begin
        rd_pend_d = issue && (ir_op == OP_READ);
        rd_data_d = rd_pend_q ? mcu_out : rd_data_q;
    end

    // Output mux: idle pattern is a read of address 0.
    always_comb begin
        mcu_op  = OP_READ;
        mcu_op0 = '0;
        mcu_op1 = '0;
        mcu_op2 = '0;
        if (issue) begin
            mcu_op  = ir_op;
            mcu_op0 = ir_op0;
            mcu_op1 = ir_op1;
            mcu_op2 = ir_op2;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_pc   = err_pc_q;
    assign rd_valid = rd_pend_q;
    assign rd_data  = rd_pend_q ? mcu_out : rd_data_q;

endmodule
